// File: rtl/seq_divider.sv
// Restoring sequential divider: one quotient bit per cycle, WIDTH+1 cycles busy.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands and results.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dv0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic             dz_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             dv0_q;
  logic             done_q;

  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  assign div_zero = (divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sa_q, sq_q;
  logic sa_in, sb_in;

  assign sa_in = dividend[WIDTH-1];
  assign sb_in = divisor[WIDTH-1];
  assign a_mag = sa_in ? -dividend : dividend;
  assign b_mag = sb_in ? -divisor : divisor;
  assign r_mag = dz_q ? dvd_q : rem_q;
  assign q_res = dz_q ? '1 : (sq_q ? -dvd_q : dvd_q);
  assign r_res = sa_q ? -r_mag : r_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q <= 1'b0;
      sq_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      sa_q <= sa_in;
      sq_q <= sa_in ^ sb_in;
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign r_mag = dz_q ? dvd_q : rem_q;
  assign q_res = dz_q ? '1 : dvd_q;
  assign r_res = r_mag;
`endif

  // Bit WIDTH of the difference is the borrow
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dsr_q};
  assign borrow   = diff[WIDTH];
  assign step_rem = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = div_zero ? DONE : RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      rmd_q  <= '0;
      dv0_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q <= a_mag;
            dsr_q <= b_mag;
            rem_q <= '0;
            cnt_q <= CW'(WIDTH);
            dz_q  <= div_zero;
          end
        end
        RUN: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], ~borrow};
          cnt_q <= cnt_q - CW'(1);
        end
        DONE: begin
          done_q <= 1'b1;
          quo_q  <= q_res;
          rmd_q  <= r_res;
          dv0_q  <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign dv0       = dv0_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and corner-sequence bench for seq_divider (WIDTH=16).
// Signed vectors are selected when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dv0;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dv0       (dv0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Issue one division; return cycles from start edge to done and busy count
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bsy, output int dlen);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bsy   = busy ? 1 : 0;
    lat   = 0;
    dlen  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bsy++;
    end
    if (lat != 0) begin
      dlen = 1;
      @(posedge clk);
      #1;
      if (done) dlen++;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bsy, dlen, nd;
    logic [W-1:0] ra, rb, eq, er;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0});
    vecs.push_back('{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0});
    vecs.push_back('{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0});
    vecs.push_back('{16'hFFF6, 16'h0003, 16'hFFFD, 16'hFFFF, 1'b0});
    vecs.push_back('{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1});
    vecs.push_back('{16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1});
    vecs.push_back('{16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFFB, 1'b1});
`else
    vecs.push_back('{16'd100,  16'd7,    16'd14,   16'd2,    1'b0});
    vecs.push_back('{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{16'd5,    16'd9,    16'd0,    16'd5,    1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
    vecs.push_back('{16'd0,    16'd5,    16'd0,    16'd0,    1'b0});
    vecs.push_back('{16'd1000, 16'd10,   16'd100,  16'd0,    1'b0});
    vecs.push_back('{16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0});
    vecs.push_back('{16'h8000, 16'h8001, 16'h0000, 16'h8000, 1'b0});
    vecs.push_back('{16'hFFFE, 16'h8000, 16'h0001, 16'h7FFE, 1'b0});
`endif

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    chk("reset_outs", {busy, done, dv0, quotient, remainder}, '0);
    #12;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      do_div(vecs[k].a, vecs[k].b, lat, bsy, dlen);
      chk($sformatf("v%0d_lat", k), lat, vecs[k].z ? 1 : 17);
      chk($sformatf("v%0d_busy", k), bsy, vecs[k].z ? 1 : 17);
      chk($sformatf("v%0d_dlen", k), dlen, 1);
      chk($sformatf("v%0d_q", k), quotient, vecs[k].q);
      chk($sformatf("v%0d_r", k), remainder, vecs[k].r);
      chk($sformatf("v%0d_dv0", k), dv0, vecs[k].z);
    end

    // Held results stay put while idle
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", quotient, vecs[vecs.size()-1].q);
    chk("hold_r", remainder, vecs[vecs.size()-1].r);

    // Start pulsed mid-run with other operands must be ignored
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 4) begin
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 16'd5;
      end
      if (i == 5) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("ign_lat", lat, 17);
    chk("ign_q", quotient, 16'd14);
    chk("ign_r", remainder, 16'd2);

    // Reset mid-run aborts without done
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_outs", {busy, done, dv0, quotient, remainder}, '0);
    @(negedge clk);
    rst = 1'b0;
    nd  = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    chk("abort_quiet", nd, 0);
    do_div(16'd5, 16'd9, lat, bsy, dlen);
    chk("post_rst_lat", lat, 17);
    chk("post_rst_q", quotient, 16'd0);
    chk("post_rst_r", remainder, 16'd5);

    // Start held high: ignored in DONE, accepted at first IDLE edge
    @(negedge clk);
    dividend = 16'd200;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = 16'd10;
    nd = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (nd == 1) begin
          chk("held1_lat", i, 17);
          chk("held1_q", quotient, 16'd66);
          chk("held1_r", remainder, 16'd2);
        end else begin
          start = 1'b0;
          chk("held2_lat", i, 35);
          chk("held2_q", quotient, 16'd3);
          chk("held2_r", remainder, 16'd1);
          break;
        end
      end
    end
    start = 1'b0;
    chk("held_count", nd, 2);

    // Short random regression against the arithmetic identity
    for (int n = 0; n < 300; n++) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      ra = W'($urandom_range(0, 16'h7FFF));
      rb = W'($urandom_range(1, 16'h7FFF));
`else
      ra = W'($urandom);
      rb = W'($urandom_range(1, 16'hFFFF));
`endif
      eq = ra / rb;
      er = ra % rb;
      do_div(ra, rb, lat, bsy, dlen);
      chk($sformatf("rnd%0d_lat", n), lat, 17);
      chk($sformatf("rnd%0d_qr", n), {quotient, remainder}, {eq, er});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
